wb_spi_master: RTL and testbench
================================

WB_SPI_MASTER -- requirements
Module: wb_spi_master

Interface
REQ-001 The block SHALL have parameter N_CS, default 3, giving the number of chip-select lines (1..16).
REQ-002 The block SHALL have parameter DW, default 32, giving the maximum transfer length in bits (8..32).
REQ-003 The block SHALL have parameter RST_DIV, default 8'd4, giving the reset value of the SCLK divider field.
REQ-004 One clock and asynchronous active-high reset: BOARD_CLOCK  in  1  system and Wishbone clock; RST  in  1  asynchronous, active-high reset.
REQ-005 adr_i  in  32  Wishbone address; only bits [3:2] are decoded.
REQ-006 dat_i  in  32  write data; dat_o  out  32  read data; sel_i  in  4  byte selects, ignored (full-word access only).
REQ-007 cyc_i, stb_i, we_i  in  1 each  Wishbone classic-cycle controls.
REQ-008 ack_o, err_o, rty_o  out  1 each  cycle termination signals; rty_o is tied 0.
REQ-009 SPI_MISO  in  1; SPI_MOSI  out  1; SPI_SCLK  out  1; SPI_CS  out  N_CS, active-low chip selects.
REQ-010 SPI_INT  out  1  level interrupt, high when DONE=1 and INT_EN=1.

Function
REQ-011 Register map: 0x0 CTRL, 0x4 TXDATA, 0x8 RXDATA (read-only), 0xC STATUS.
REQ-012 CTRL fields: [0] START (write-1, reads 0); [1] CPOL; [2] CPHA; [3] INT_EN; [11:8] CS index; [20:16] LEN, where the transfer is LEN+1 bits; [31:24] DIV.
REQ-013 STATUS fields: [0] BUSY (read-only); [1] DONE (sticky, write-1-to-clear).
REQ-014 Termination: ack_o or err_o SHALL rise exactly one cycle after cyc_i&stb_i and last one cycle; there SHALL be no back-to-back termination without stb_i dropping.
REQ-015 err_o instead of ack_o, with no state change, SHALL result from:
- a CTRL or TXDATA write while BUSY=1;
- START=1 with CS index >= N_CS;
- START=1 with LEN >= DW.
REQ-016 FSM states: IDLE, SETUP, SHIFT, HOLD.
REQ-017 Transitions:
- IDLE->SETUP on an accepted START; BUSY=1 and DONE cleared in that cycle.
- SETUP: the selected SPI_CS goes low; the block waits one half-period, then enters SHIFT.
- SHIFT: generates 2*(LEN+1) SCLK edges, then enters HOLD.
- HOLD: waits one half-period, then deasserts SPI_CS, sets BUSY=0 and DONE=1, and enters IDLE.
REQ-018 Half-period SHALL be DIV+1 BOARD_CLOCK cycles; DIV=0 gives SCLK = BOARD_CLOCK/2.
REQ-019 SCLK idle level SHALL equal CPOL, sampled at START. CPHA=0: MOSI valid from SETUP, sample on the first edge of each bit, shift on the second. CPHA=1: shift on the first edge, sample on the second.
REQ-020 Data SHALL be MSB-first: TXDATA[LEN] first, TXDATA[0] last.
REQ-021 RXDATA SHALL be right-justified in [LEN:0] with upper bits zero, and update only on entry to IDLE after the transfer.
REQ-022 CTRL, TXDATA and DIV SHALL be sampled at START; later register reads SHALL return the sampled values.
REQ-023 A DONE write-1-to-clear coincident with completion SHALL leave DONE=1 (set wins).
REQ-024 Outside SETUP/SHIFT/HOLD, every SPI_CS bit SHALL be 1.

Reset
REQ-025 While RST=1, regardless of clock:
- state=IDLE; SPI_CS all 1; SPI_SCLK=0; SPI_MOSI=0;
- ack_o=err_o=rty_o=0; SPI_INT=0; dat_o=0;
- CTRL=0 except DIV=RST_DIV; TXDATA=0; RXDATA=0; BUSY=0; DONE=0.
REQ-026 RST asserted mid-transfer SHALL abort it immediately, with no DONE flag and RXDATA cleared.

Structure
REQ-027 Package wb_spi_pkg SHALL hold the register offsets, CTRL/STATUS bit positions and the FSM state encoding.
REQ-028 Sub-module spi_clk_gen SHALL hold the DIV counter and issue single-cycle lead/trail edge strobes to the FSM.

Verification
REQ-029 Mode 0, DIV=0, LEN=7, CS=1, TX=0xA5, MISO looped to MOSI -> 16 SCLK edges, SPI_CS=3'b101 throughout, RXDATA=0x000000A5, DONE=1.
REQ-030 Mode 3, DIV=3, LEN=31, TX=0xDEADBEEF, MISO=1 -> SCLK idles high, half-period 4 cycles, RXDATA=0xFFFFFFFF.
REQ-031 START with CS index=3 (N_CS=3), and a write while BUSY -> err_o pulse, state and registers unchanged.
REQ-032 INT_EN=1 -> SPI_INT rises with DONE; a W1C on the same cycle as completion leaves DONE=1; a later W1C drops SPI_INT.
REQ-033 RST pulsed during SHIFT of a 24-bit transfer -> SPI_CS=3'b111, SCLK=CPOL reset value 0, BUSY=0, RXDATA=0 asynchronously.
REQ-034 Back-to-back transfers with LEN=0 (1 bit) -> exactly 2 SCLK edges each, RXDATA[0]=MISO, upper bits 0.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Wishbone SPI master: shared register map,
// field positions and FSM encoding.
package wb_spi_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_TXDATA = 2'd1;
  localparam logic [1:0] ADR_RXDATA = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_INT_EN  = 3;
  localparam int CTRL_CS_LSB  = 8;
  localparam int CTRL_LEN_LSB = 16;
  localparam int CTRL_DIV_LSB = 24;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider for the SPI master:
// tick every DIV+1 cycles, split into lead/trail.
module spi_clk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       shift,
  input  logic [7:0] div,
  output logic       tick,
  output logic       lead,
  output logic       trail
);

  logic [7:0] cnt;
  logic       phase;

  assign tick  = run && (cnt == div);
  assign lead  = tick & shift & ~phase;
  assign trail = tick & shift & phase;

  // count cycles within the current half-period
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!run || tick)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

  // alternate lead and trail edges while shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= 1'b0;
    else if (!shift)
      phase <= 1'b0;
    else if (tick)
      phase <= ~phase;
  end

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone classic slave driving a single-lane
// SPI master with programmable mode/length/divider.
module wb_spi_master
  import wb_spi_pkg::*;
#(
  parameter int         N_CS    = 3,
  parameter int         DW      = 32,
  parameter logic [7:0] RST_DIV = 8'd4
) (
  input  logic            BOARD_CLOCK,
  input  logic            RST,
  input  logic [31:0]     adr_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  input  logic [3:0]      sel_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  output logic            ack_o,
  output logic            err_o,
  output logic            rty_o,
  input  logic            SPI_MISO,
  output logic            SPI_MOSI,
  output logic            SPI_SCLK,
  output logic [N_CS-1:0] SPI_CS,
  output logic            SPI_INT
);

  state_t      state_q, state_d;
  logic        served_q;
  logic        cpol_q, cpha_q, int_en_q;
  logic [3:0]  cs_q;
  logic [4:0]  len_q, bit_q;
  logic [7:0]  div_q;
  logic [31:0] tx_q, rx_q, rx_sh, rd;
  logic        done_q, sclk_q, mosi_q;
  logic        tick, lead, trail, smp;
  logic        req, wr, wr_ok, fault, start;
  logic        busy, finish;
  logic [1:0]  a;
  logic [N_CS-1:0] cs_sel;
  logic        unused;

  assign unused = ^{sel_i, adr_i[31:4], adr_i[1:0]};

  assign a     = adr_i[3:2];
  assign busy  = (state_q != S_IDLE);
  assign req   = cyc_i & stb_i & ~served_q;
  assign wr    = req & we_i;
  assign fault = wr & (
      (busy && (a == ADR_CTRL || a == ADR_TXDATA)) ||
      (a == ADR_CTRL && dat_i[CTRL_START] &&
       (({28'd0, dat_i[CTRL_CS_LSB +: 4]} >= 32'(N_CS)) ||
        ({27'd0, dat_i[CTRL_LEN_LSB +: 5]} >= 32'(DW)))));
  assign wr_ok = wr & ~fault;
  assign start = wr_ok && a == ADR_CTRL && dat_i[CTRL_START];
  assign smp   = cpha_q ? trail : lead;

  assign rty_o    = 1'b0;
  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_INT  = done_q & int_en_q;
  assign SPI_CS   = cs_sel;

  spi_clk_gen u_clk (
    .clk   (BOARD_CLOCK),
    .rst   (RST),
    .run   (busy),
    .shift (state_q == S_SHIFT),
    .div   (div_q),
    .tick  (tick),
    .lead  (lead),
    .trail (trail)
  );

  // state register
  always_ff @(posedge BOARD_CLOCK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state and completion strobe
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: if (tick) state_d = S_SHIFT;
      S_SHIFT: if (trail && bit_q == len_q)
                 state_d = S_HOLD;
      S_HOLD:  if (tick) begin
                 state_d = S_IDLE;
                 finish  = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  // chip-select decode, only while a transfer is active
  always_comb begin
    cs_sel = '1;
    for (int i = 0; i < N_CS; i++)
      if (busy && cs_q == 4'(i)) cs_sel[i] = 1'b0;
  end

  // register read mux
  always_comb begin
    rd = '0;
    unique case (a)
      ADR_CTRL:   rd = {div_q, 3'b0, len_q, 4'b0, cs_q,
                        4'b0, int_en_q, cpha_q, cpol_q, 1'b0};
      ADR_TXDATA: rd = tx_q;
      ADR_RXDATA: rd = rx_q;
      ADR_STATUS: rd = {30'd0, done_q, busy};
      default:    rd = '0;
    endcase
  end

  // bus termination and register file
  always_ff @(posedge BOARD_CLOCK or posedge RST) begin
    if (RST) begin
      served_q <= 1'b0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      int_en_q <= 1'b0;
      cs_q     <= '0;
      len_q    <= '0;
      div_q    <= RST_DIV;
      tx_q     <= '0;
      rx_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      served_q <= cyc_i & stb_i;
      ack_o    <= req & ~fault;
      err_o    <= fault;
      dat_o    <= (req && !we_i) ? rd : '0;
      if (wr_ok && a == ADR_CTRL) begin
        cpol_q   <= dat_i[CTRL_CPOL];
        cpha_q   <= dat_i[CTRL_CPHA];
        int_en_q <= dat_i[CTRL_INT_EN];
        cs_q     <= dat_i[CTRL_CS_LSB +: 4];
        len_q    <= dat_i[CTRL_LEN_LSB +: 5];
        div_q    <= dat_i[CTRL_DIV_LSB +: 8];
      end
      if (wr_ok && a == ADR_TXDATA)
        tx_q <= dat_i;
      if (finish)
        rx_q <= rx_sh;
      if (finish)
        done_q <= 1'b1;
      else if (start)
        done_q <= 1'b0;
      else if (wr_ok && a == ADR_STATUS &&
               dat_i[STAT_DONE])
        done_q <= 1'b0;
    end
  end

  // SCLK, MOSI and receive shift register
  always_ff @(posedge BOARD_CLOCK or posedge RST) begin
    if (RST) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rx_sh  <= '0;
      bit_q  <= '0;
    end else if (start) begin
      sclk_q <= dat_i[CTRL_CPOL];
      mosi_q <= tx_q[dat_i[CTRL_LEN_LSB +: 5]];
      rx_sh  <= '0;
      bit_q  <= '0;
    end else begin
      if (lead | trail)
        sclk_q <= ~sclk_q;
      if (smp)
        rx_sh <= {rx_sh[30:0], SPI_MISO};
      if (trail)
        bit_q <= bit_q + 5'd1;
      if (lead && cpha_q)
        mosi_q <= tx_q[len_q - bit_q];
      if (trail && !cpha_q && bit_q != len_q)
        mosi_q <= tx_q[len_q - bit_q - 5'd1];
    end
  end

endmodule

// File: tb/tb_wb_spi_master.sv
// Self-checking bench for wb_spi_master:
// register reads go through an expected-value queue.
module tb_wb_spi_master;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_TX   = 4'h4;
  localparam logic [3:0] A_RX   = 4'h8;
  localparam logic [3:0] A_ST   = 4'hC;

  logic        clk, rst;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic        ack_o, err_o, rty_o;
  logic        miso, mosi, sclk, intr;
  logic [2:0]  cs;

  logic        loop_en, miso_val;
  logic        cur_cpha;
  logic [2:0]  cs_exp;

  int n_chk, n_pass;

  logic [31:0] sb_q[$];
  string       sb_tag[$];

  // transfer monitor state
  int          xedges, cs_err, mcnt;
  logic        in_x, seen, sclk_prev;
  logic [31:0] mosi_cap;
  int          gaps[$];

  assign miso = loop_en ? mosi : miso_val;

  wb_spi_master dut (
    .BOARD_CLOCK (clk),
    .RST         (rst),
    .adr_i       (adr),
    .dat_i       (dat_w),
    .dat_o       (dat_r),
    .sel_i       (sel),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .we_i        (we),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rty_o       (rty_o),
    .SPI_MISO    (miso),
    .SPI_MOSI    (mosi),
    .SPI_SCLK    (sclk),
    .SPI_CS      (cs),
    .SPI_INT     (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic wb(input logic w,
                    input logic [3:0] ad,
                    input logic [31:0] d,
                    output logic [31:0] q,
                    output logic ak,
                    output logic er,
                    output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = {28'd0, ad}; dat_w = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_o && !err_o && lat < 8);
    ak = ack_o; er = err_o; q = dat_r;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag,
                    input logic [3:0] ad,
                    input logic [31:0] d,
                    input logic exp_err);
    logic [31:0] q; logic ak, er; int lat;
    wb(1'b1, ad, d, q, ak, er, lat);
    chk({tag, "_term"}, {30'd0, er, ak},
        exp_err ? 32'd2 : 32'd1);
  endtask

  task automatic expect_rd(input string tag,
                           input logic [3:0] ad,
                           input logic [31:0] e);
    logic [31:0] q; logic ak, er; int lat;
    sb_q.push_back(e);
    sb_tag.push_back(tag);
    wb(1'b0, ad, 32'd0, q, ak, er, lat);
    if (!ak) q = 32'hDEAD_0ACC;
    chk(sb_tag.pop_front(), q, sb_q.pop_front());
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] q; logic ak, er; int lat, k;
    k = 0;
    do begin
      wb(1'b0, A_ST, 32'd0, q, ak, er, lat);
      k++;
    end while (q[0] && k < 300);
    chk(tag, {31'd0, q[0]}, 32'd0);
  endtask

  // watch SCLK/MOSI/CS on falling BOARD_CLOCK edges
  initial begin
    in_x = 1'b0; seen = 1'b0; sclk_prev = 1'b0;
    xedges = 0; cs_err = 0; mcnt = 0;
    mosi_cap = '0;
    forever begin
      @(negedge clk);
      if (cs == 3'b111) begin
        in_x = 1'b0;
      end else if (!in_x) begin
        in_x = 1'b1; xedges = 0; seen = 1'b0;
        mcnt = 0; mosi_cap = '0; gaps.delete();
        if (cs != cs_exp) cs_err++;
      end else begin
        mcnt++;
        if (sclk != sclk_prev) begin
          if (seen) gaps.push_back(mcnt);
          seen = 1'b1; mcnt = 0;
          if ((xedges % 2) == (cur_cpha ? 1 : 0))
            mosi_cap = {mosi_cap[30:0], mosi};
          xedges++;
        end
        if (cs != cs_exp) cs_err++;
      end
      sclk_prev = sclk;
    end
  end

  initial begin
    logic [31:0] q; logic ak, er; int lat;
    int ce0, bad, acks;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = 4'hF;
    loop_en = 1'b1; miso_val = 1'b0;
    cur_cpha = 1'b0; cs_exp = 3'b111;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs", {29'd0, cs}, 32'h7);
    chk("rst_lines", {27'd0, sclk, mosi, intr,
        ack_o | err_o, rty_o}, 32'd0);
    chk("rst_dat", dat_r, 32'd0);
    rst = 1'b0;
    expect_rd("rst_ctrl", A_CTRL, 32'h0400_0000);
    expect_rd("rst_tx", A_TX, 32'd0);
    expect_rd("rst_rx", A_RX, 32'd0);
    expect_rd("rst_st", A_ST, 32'd0);

    // mode 0, DIV 0, 8 bits, CS 1, loopback
    wb(1'b1, A_TX, 32'hA5, q, ak, er, lat);
    chk("ack_lat", 32'(lat), 32'd1);
    cs_exp = 3'b101; cur_cpha = 1'b0; ce0 = cs_err;
    wr("m0_start", A_CTRL, 32'h0007_0101, 1'b0);
    wait_idle("m0_wait");
    chk("m0_edges", 32'(xedges), 32'd16);
    chk("m0_cs", 32'(cs_err - ce0), 32'd0);
    chk("m0_mosi", mosi_cap, 32'hA5);
    expect_rd("m0_rx", A_RX, 32'h0000_00A5);
    expect_rd("m0_st", A_ST, 32'h2);
    expect_rd("m0_ctrl", A_CTRL, 32'h0007_0100);

    // mode 3, DIV 3, 32 bits, MISO held high
    wr("m3_tx", A_TX, 32'hDEAD_BEEF, 1'b0);
    loop_en = 1'b0; miso_val = 1'b1;
    cs_exp = 3'b110; cur_cpha = 1'b1; ce0 = cs_err;
    wr("m3_start", A_CTRL, 32'h031F_0007, 1'b0);
    expect_rd("m3_busy_st", A_ST, 32'h1);
    expect_rd("m3_busy_rx", A_RX, 32'h0000_00A5);
    wait_idle("m3_wait");
    chk("m3_edges", 32'(xedges), 32'd64);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 4) bad++;
    chk("m3_ngaps", 32'(gaps.size()), 32'd63);
    chk("m3_gap4", 32'(bad), 32'd0);
    chk("m3_sclk_idle", {31'd0, sclk}, 32'd1);
    chk("m3_cs", 32'(cs_err - ce0), 32'd0);
    chk("m3_mosi", mosi_cap, 32'hDEAD_BEEF);
    expect_rd("m3_rx", A_RX, 32'hFFFF_FFFF);

    // bad chip-select index
    wr("bad_cs", A_CTRL, 32'h0007_0301, 1'b1);
    expect_rd("bad_cs_ctrl", A_CTRL, 32'h031F_0006);
    expect_rd("bad_cs_st", A_ST, 32'h2);

    // 24-bit mode 2 transfer, writes while busy
    wr("b_tx", A_TX, 32'h00AB_CDEF, 1'b0);
    cs_exp = 3'b011; cur_cpha = 1'b0;
    wr("b_start", A_CTRL, 32'h0317_0203, 1'b0);
    wr("b_wtx", A_TX, 32'h1234_5678, 1'b1);
    wr("b_wctrl", A_CTRL, 32'h0, 1'b1);
    expect_rd("b_tx_keep", A_TX, 32'h00AB_CDEF);
    expect_rd("b_ctrl_keep", A_CTRL, 32'h0317_0202);
    expect_rd("b_st", A_ST, 32'h1);

    // asynchronous reset in the middle of SHIFT
    repeat (10) @(posedge clk);
    #2;
    chk("b_cs_low", {29'd0, cs}, 32'h3);
    rst = 1'b1;
    #1;
    chk("ar_cs", {29'd0, cs}, 32'h7);
    chk("ar_sclk", {31'd0, sclk}, 32'd0);
    chk("ar_mosi", {31'd0, mosi}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_rd("ar_st", A_ST, 32'd0);
    expect_rd("ar_rx", A_RX, 32'd0);
    expect_rd("ar_ctrl", A_CTRL, 32'h0400_0000);

    // interrupt, W1C on the completion cycle
    wr("i_tx", A_TX, 32'h3C, 1'b0);
    loop_en = 1'b1; cs_exp = 3'b110;
    wr("i_start", A_CTRL, 32'h0007_0009, 1'b0);
    repeat (16) @(negedge clk);
    wr("i_w1c_race", A_ST, 32'h2, 1'b0);
    chk("i_int_hi", {31'd0, intr}, 32'd1);
    expect_rd("i_st", A_ST, 32'h2);
    expect_rd("i_rx", A_RX, 32'h3C);
    wr("i_w1c", A_ST, 32'h2, 1'b0);
    chk("i_int_lo", {31'd0, intr}, 32'd0);
    expect_rd("i_st2", A_ST, 32'h0);

    // back-to-back single-bit transfers
    loop_en = 1'b0; miso_val = 1'b1;
    wr("l0_tx", A_TX, 32'h1, 1'b0);
    wr("l0_start", A_CTRL, 32'h0100_0001, 1'b0);
    wait_idle("l0_wait");
    chk("l0_edges", 32'(xedges), 32'd2);
    chk("l0_mosi", mosi_cap, 32'h1);
    expect_rd("l0_rx", A_RX, 32'h1);
    miso_val = 1'b0;
    wr("l1_tx", A_TX, 32'hFFFF_FFFE, 1'b0);
    wr("l1_start", A_CTRL, 32'h0100_0001, 1'b0);
    wait_idle("l1_wait");
    chk("l1_edges", 32'(xedges), 32'd2);
    chk("l1_mosi", mosi_cap, 32'h0);
    expect_rd("l1_rx", A_RX, 32'h0);

    // strobe held high: only one termination
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = {28'd0, A_ST};
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_o) acks++;
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    chk("no_b2b_ack", 32'(acks), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
